// File: rtl/lpif_pkg.sv
// Shared LPIF definitions: state_sts codes, stall FSM states, flit record.
// Imported by the gearbox top, its FIFO and interface.
package lpif_pkg;

  localparam logic [3:0] STS_RESET   = 4'h0;
  localparam logic [3:0] STS_ACTIVE  = 4'h1;
  localparam logic [3:0] STS_RETRAIN = 4'hB;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REQ,
    ST_STALLED,
    ST_RELEASE
  } stall_st_t;

  typedef struct packed {
    logic [7:0][7:0] data;
    logic [7:0]      valid;
    logic [7:0]      tlp_s;
    logic [7:0]      tlp_e;
    logic [7:0]      dllp_s;
    logic [7:0]      dllp_e;
  } flit_t;

  // Legal valid masks are a run of ones starting at lane 0.
  function automatic logic valid_contig(logic [7:0] v);
    return ((v & (v + 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/lpif_tx_gearbox_if.sv
// LPIF transmit bundle: link-layer flit side, PHY stall/state side, framer side.
// master = link layer + framer environment, slave = gearbox.
interface lpif_tx_gearbox_if;

  logic [7:0][7:0] lp_data;
  logic [7:0]      lp_valid;
  logic            lp_irdy;
  logic            pl_trdy;
  logic [7:0]      lp_tlp_start;
  logic [7:0]      lp_tlp_end;
  logic [7:0]      lp_dllp_start;
  logic [7:0]      lp_dllp_end;
  logic [3:0]      pl_state_sts;
  logic            stall_in;
  logic            pl_stall_req;
  logic            lp_stall_ack;
  logic [31:0]     tx_data;
  logic [3:0]      tx_byte_valid;
  logic [3:0]      tx_tlp_start;
  logic [3:0]      tx_tlp_end;
  logic [3:0]      tx_dllp_start;
  logic [3:0]      tx_dllp_end;
  logic            tx_valid;
  logic            tx_ready;
  logic            err_marker;

  modport master (
    output lp_data, lp_valid, lp_irdy,
    output lp_tlp_start, lp_tlp_end,
    output lp_dllp_start, lp_dllp_end,
    output pl_state_sts, stall_in, lp_stall_ack,
    output tx_ready,
    input  pl_trdy, pl_stall_req, err_marker,
    input  tx_data, tx_byte_valid, tx_valid,
    input  tx_tlp_start, tx_tlp_end,
    input  tx_dllp_start, tx_dllp_end
  );

  modport slave (
    input  lp_data, lp_valid, lp_irdy,
    input  lp_tlp_start, lp_tlp_end,
    input  lp_dllp_start, lp_dllp_end,
    input  pl_state_sts, stall_in, lp_stall_ack,
    input  tx_ready,
    output pl_trdy, pl_stall_req, err_marker,
    output tx_data, tx_byte_valid, tx_valid,
    output tx_tlp_start, tx_tlp_end,
    output tx_dllp_start, tx_dllp_end
  );

endinterface

// File: rtl/lpif_flit_fifo.sv
// FIFO_DEPTH-entry flit buffer; ports: clk, reset, push/din, pop/dout, full, empty.
// Caller never pushes while full.
module lpif_flit_fifo
  import lpif_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  flit_t din,
  input  logic  pop,
  output flit_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  flit_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/lpif_tx_gearbox.sv
// LPIF transmit gearbox: 8-byte flits in, 4-byte half-flits out, with stall FSM.
// Ports: PCLK, reset (sync, active high), bus (lpif_tx_gearbox_if.slave).
module lpif_tx_gearbox
  import lpif_pkg::*;
(
  input logic               PCLK,
  input logic               reset,
  lpif_tx_gearbox_if.slave  bus
);

  flit_t     in_flit;
  flit_t     head;
  logic      full, empty;
  logic      trdy, acc, push, pop;
  stall_st_t st, st_nxt;
  logic      run_ok, stall_req;
  logic      hp, lo_nz, hi_nz, sel, xfer;
  logic      pkt_open, open_c, perr, err_q;

  assign in_flit = '{
    data:   bus.lp_data,
    valid:  bus.lp_valid,
    tlp_s:  bus.lp_tlp_start,
    tlp_e:  bus.lp_tlp_end,
    dllp_s: bus.lp_dllp_start,
    dllp_e: bus.lp_dllp_end
  };

  assign acc  = bus.lp_irdy & trdy;
  // Empty flits are acknowledged but never stored.
  assign push = acc & (|bus.lp_valid);

  lpif_flit_fifo u_fifo (
    .clk   (PCLK),
    .reset (reset),
    .push  (push),
    .din   (in_flit),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge PCLK) begin
    if (reset) st <= ST_RUN;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_RUN:     if (bus.stall_in)      st_nxt = ST_REQ;
      ST_REQ:     if (bus.lp_stall_ack)  st_nxt = ST_STALLED;
      ST_STALLED: if (!bus.stall_in)     st_nxt = ST_RELEASE;
      ST_RELEASE: if (!bus.lp_stall_ack) st_nxt = ST_RUN;
      default:                           st_nxt = ST_RUN;
    endcase
  end

  // Acceptance closes in the same cycle the ack arrives in REQ.
  always_comb begin
    stall_req = (st == ST_REQ) | (st == ST_STALLED);
    run_ok    = (st == ST_RUN) |
                ((st == ST_REQ) & ~bus.lp_stall_ack);
  end

  assign trdy = ~reset & ~full & run_ok &
                (bus.pl_state_sts == STS_ACTIVE);
  assign bus.pl_trdy      = trdy;
  assign bus.pl_stall_req = stall_req;

  // Stored flits always have a non-empty half, so an empty low
  // half simply redirects the pointer to the high half.
  assign lo_nz = |head.valid[3:0];
  assign hi_nz = |head.valid[7:4];
  assign sel   = hp | ~lo_nz;
  assign xfer  = ~empty & bus.tx_ready;
  assign pop   = xfer & (sel | ~hi_nz);

  always_ff @(posedge PCLK) begin
    if (reset)     hp <= 1'b0;
    else if (xfer) hp <= ~pop;
  end

  always_comb begin
    bus.tx_valid      = ~empty;
    bus.tx_data       = '0;
    bus.tx_byte_valid = '0;
    bus.tx_tlp_start  = '0;
    bus.tx_tlp_end    = '0;
    bus.tx_dllp_start = '0;
    bus.tx_dllp_end   = '0;
    if (!empty) begin
      if (sel) begin
        bus.tx_data       = head.data[7:4];
        bus.tx_byte_valid = head.valid[7:4];
        bus.tx_tlp_start  = head.tlp_s[7:4];
        bus.tx_tlp_end    = head.tlp_e[7:4];
        bus.tx_dllp_start = head.dllp_s[7:4];
        bus.tx_dllp_end   = head.dllp_e[7:4];
      end else begin
        bus.tx_data       = head.data[3:0];
        bus.tx_byte_valid = head.valid[3:0];
        bus.tx_tlp_start  = head.tlp_s[3:0];
        bus.tx_tlp_end    = head.tlp_e[3:0];
        bus.tx_dllp_start = head.dllp_s[3:0];
        bus.tx_dllp_end   = head.dllp_e[3:0];
      end
    end
  end

  // Walk lanes in order; a start on a lane precedes its end.
  always_comb begin
    open_c = pkt_open;
    perr   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.lp_tlp_start[i] | bus.lp_dllp_start[i]) begin
        if (open_c) perr = 1'b1;
        open_c = 1'b1;
      end
      if (bus.lp_tlp_end[i] | bus.lp_dllp_end[i]) begin
        if (!open_c) perr = 1'b1;
        open_c = 1'b0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      pkt_open <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= acc & (perr | ~valid_contig(bus.lp_valid));
      if (acc) pkt_open <= open_c;
    end
  end

  assign bus.err_marker = err_q;

endmodule

// File: tb/tb_lpif_tx_gearbox.sv
// Directed bench for lpif_tx_gearbox: vector table plus stall/backpressure/reset sequences.
// Expected values are hand-computed constants or derived from the stimulus bytes.
module tb_lpif_tx_gearbox;
  import lpif_pkg::*;

  logic PCLK = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 PCLK = ~PCLK;

  lpif_tx_gearbox_if bus ();

  lpif_tx_gearbox dut (
    .PCLK  (PCLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] v;
    logic [7:0] ts;
    logic [7:0] te;
    int         n;
    int         h0;
    logic [3:0] bv0;
    logic [3:0] bv1;
    logic [3:0] ts0;
    logic [3:0] tel;
    logic       err;
  } vec_t;

  vec_t vt [11];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] half_of(int base, int h);
    logic [31:0] r;
    for (int j = 0; j < 4; j++)
      r[j*8 +: 8] = 8'(base + h*4 + j);
    return r;
  endfunction

  task automatic idle_inputs();
    bus.lp_irdy       = 1'b0;
    bus.lp_valid      = '0;
    bus.lp_data       = '0;
    bus.lp_tlp_start  = '0;
    bus.lp_tlp_end    = '0;
    bus.lp_dllp_start = '0;
    bus.lp_dllp_end   = '0;
  endtask

  task automatic drive_flit(int base, logic [7:0] v);
    for (int i = 0; i < 8; i++)
      bus.lp_data[i] = 8'(base + i);
    bus.lp_valid = v;
    bus.lp_irdy  = 1'b1;
  endtask

  task automatic run_vec(int k);
    logic [31:0] d [2];
    logic [3:0]  bv [2];
    logic [3:0]  ts_first;
    logic [3:0]  te_last;
    int          got;
    int          base;
    base = k * 16;
    @(negedge PCLK);
    drive_flit(base, vt[k].v);
    bus.lp_tlp_start = vt[k].ts;
    bus.lp_tlp_end   = vt[k].te;
    bus.tx_ready     = 1'b1;
    #1;
    chk($sformatf("v%0d trdy", k), 32'(bus.pl_trdy), 32'd1);
    @(negedge PCLK);
    idle_inputs();
    #1;
    chk($sformatf("v%0d err", k), 32'(bus.err_marker), 32'(vt[k].err));
    got = 0;
    ts_first = '0;
    te_last = '0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge PCLK);
        #1;
      end
      if (bus.tx_valid) begin
        if (got < 2) begin
          d[got]  = bus.tx_data;
          bv[got] = bus.tx_byte_valid;
        end
        if (got == 0) ts_first = bus.tx_tlp_start;
        te_last = bus.tx_tlp_end;
        got++;
      end
    end
    chk($sformatf("v%0d halves", k), 32'(got), 32'(vt[k].n));
    if (vt[k].n >= 1 && got >= 1) begin
      chk($sformatf("v%0d data0", k), d[0], half_of(base, vt[k].h0));
      chk($sformatf("v%0d bv0", k), 32'(bv[0]), 32'(vt[k].bv0));
      chk($sformatf("v%0d ts0", k), 32'(ts_first), 32'(vt[k].ts0));
      chk($sformatf("v%0d te_last", k), 32'(te_last), 32'(vt[k].tel));
    end
    if (vt[k].n == 2 && got >= 2) begin
      chk($sformatf("v%0d data1", k), d[1], half_of(base, 1));
      chk($sformatf("v%0d bv1", k), 32'(bv[1]), 32'(vt[k].bv1));
    end
  endtask

  initial begin
    int got;
    int seen;
    //        v      ts     te     n  h0 bv0   bv1   ts0   tel   err
    vt[0]  = '{8'hFF, 8'h00, 8'h00, 2, 0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
    vt[1]  = '{8'h0F, 8'h00, 8'h00, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[2]  = '{8'h03, 8'h00, 8'h00, 1, 0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[3]  = '{8'hF0, 8'h00, 8'h00, 1, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
    vt[4]  = '{8'h00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[5]  = '{8'h05, 8'h00, 8'h00, 1, 0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1};
    vt[6]  = '{8'h3F, 8'h01, 8'h20, 2, 0, 4'hF, 4'h3, 4'h1, 4'h2, 1'b0};
    vt[7]  = '{8'hFF, 8'h00, 8'h01, 2, 0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1};
    vt[8]  = '{8'h1F, 8'h01, 8'h00, 2, 0, 4'hF, 4'h1, 4'h1, 4'h0, 1'b0};
    vt[9]  = '{8'h7F, 8'h01, 8'h00, 2, 0, 4'hF, 4'h7, 4'h1, 4'h0, 1'b1};
    vt[10] = '{8'hFF, 8'h00, 8'h80, 2, 0, 4'hF, 4'hF, 4'h0, 4'h8, 1'b0};

    reset = 1'b1;
    idle_inputs();
    bus.pl_state_sts = STS_ACTIVE;
    bus.stall_in     = 1'b0;
    bus.lp_stall_ack = 1'b0;
    bus.tx_ready     = 1'b1;
    repeat (2) @(negedge PCLK);
    #1;
    chk("rst trdy", 32'(bus.pl_trdy), 32'd0);
    chk("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst stall_req", 32'(bus.pl_stall_req), 32'd0);
    chk("rst err", 32'(bus.err_marker), 32'd0);
    chk("rst bv", 32'(bus.tx_byte_valid), 32'd0);
    chk("rst marks", 32'({bus.tx_tlp_start, bus.tx_tlp_end,
                          bus.tx_dllp_start, bus.tx_dllp_end}), 32'd0);
    reset = 1'b0;
    @(negedge PCLK);
    #1;
    chk("post-rst trdy", 32'(bus.pl_trdy), 32'd1);

    for (int k = 0; k < 11; k++) run_vec(k);

    // Backpressure: four flits fill the FIFO, fifth is refused.
    for (int f = 0; f < 5; f++) begin
      @(negedge PCLK);
      drive_flit(16 * (f + 1), 8'hFF);
      bus.tx_ready = 1'b0;
      #1;
      chk($sformatf("bp trdy%0d", f), 32'(bus.pl_trdy), 32'(f < 4));
      if (f >= 1) begin
        chk($sformatf("bp hold%0d", f), bus.tx_data, 32'h13121110);
        chk($sformatf("bp tv%0d", f), 32'(bus.tx_valid), 32'd1);
      end
    end
    @(negedge PCLK);
    idle_inputs();
    bus.tx_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 12 && got < 8; c++) begin
      if (c > 0) begin
        @(negedge PCLK);
        #1;
      end
      if (bus.tx_valid) begin
        chk($sformatf("bp half%0d", got), bus.tx_data,
            half_of(16 * (got / 2 + 1), got % 2));
        got++;
      end
    end
    chk("bp count", 32'(got), 32'd8);
    @(negedge PCLK);
    #1;
    chk("bp drained", 32'(bus.tx_valid), 32'd0);

    // Stall handshake, including stall_in dropping before ack.
    bus.stall_in = 1'b1;
    #1;
    chk("st run req", 32'(bus.pl_stall_req), 32'd0);
    @(negedge PCLK);
    #1;
    chk("st req", 32'(bus.pl_stall_req), 32'd1);
    chk("st req trdy", 32'(bus.pl_trdy), 32'd1);
    bus.stall_in = 1'b0;
    @(negedge PCLK);
    #1;
    chk("st req held", 32'(bus.pl_stall_req), 32'd1);
    bus.lp_stall_ack = 1'b1;
    #1;
    chk("st ack trdy", 32'(bus.pl_trdy), 32'd0);
    @(negedge PCLK);
    #1;
    chk("st stalled req", 32'(bus.pl_stall_req), 32'd1);
    chk("st stalled trdy", 32'(bus.pl_trdy), 32'd0);
    @(negedge PCLK);
    #1;
    chk("st release req", 32'(bus.pl_stall_req), 32'd0);
    chk("st release trdy", 32'(bus.pl_trdy), 32'd0);
    bus.lp_stall_ack = 1'b0;
    @(negedge PCLK);
    #1;
    chk("st run trdy", 32'(bus.pl_trdy), 32'd1);

    bus.pl_state_sts = STS_RETRAIN;
    #1;
    chk("retrain trdy", 32'(bus.pl_trdy), 32'd0);
    bus.pl_state_sts = STS_ACTIVE;

    // Reset with three flits buffered discards them.
    for (int f = 0; f < 3; f++) begin
      @(negedge PCLK);
      drive_flit(8'h40 + 16 * f, 8'hFF);
      bus.tx_ready = 1'b0;
    end
    @(negedge PCLK);
    idle_inputs();
    #1;
    chk("pre-rst tv", 32'(bus.tx_valid), 32'd1);
    reset = 1'b1;
    @(negedge PCLK);
    reset = 1'b0;
    bus.tx_ready = 1'b1;
    #1;
    chk("rst3 tv", 32'(bus.tx_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      #1;
      if (bus.tx_valid) seen++;
    end
    chk("rst3 no emit", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
